// File: rtl/tt_div_pkg.sv
// tt_div_pkg: state encoding, widths, pin indices and operand screening for the sequential divider.
package tt_div_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_e;
  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W = 4;
  localparam int STEPS = 4;
  localparam int CNT_W = $clog2(STEPS);
  localparam int START_BIT = 4;
  localparam int BUSY_BIT = 5;
  localparam int DONE_BIT = 6;
  localparam int ERR_BIT = 7;
  localparam logic [7:0] ERR_CODE = 8'hFF;
  // A quotient only fits 4 bits when the high dividend nibble is already below the divisor.
  function automatic logic bad_operands(logic [DIVIDEND_W-1:0] d, logic [DIVISOR_W-1:0] v);
    return (v == '0) || (d[DIVIDEND_W-1:DIVISOR_W] >= v);
  endfunction
endpackage

// File: rtl/mul4x4_array.sv
// mul4x4_array: combinational 4x4 unsigned multiplier built from AND partial products and rows of full adders.
module mul4x4_array (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [4:0] row;
  logic [3:0] nxt;
  logic       cy, x, y;
  always_comb begin
    row = {1'b0, a & {4{b[0]}}};
    nxt = '0;
    cy = 1'b0;
    x = 1'b0;
    y = 1'b0;
    p = '0;
    p[0] = row[0];
    for (int i = 1; i < 4; i++) begin
      cy = 1'b0;
      for (int j = 0; j < 4; j++) begin
        x = a[j] & b[i];
        y = row[j+1];
        nxt[j] = x ^ y ^ cy;
        cy = (x & y) | (cy & (x ^ y));
      end
      row = {cy, nxt};
      p[i] = row[0];
    end
    p[7:4] = row[4:1];
  end
endmodule

// File: rtl/tt_um_seq_divider_hhrb98.sv
// tt_um_seq_divider_hhrb98: 8/4 restoring divider, one quotient bit per cycle.
// Define DIVIDER_SELFCHECK_EN to add a CHECK state that re-multiplies Q*V+R against D.
module tt_um_seq_divider_hhrb98
  import tt_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [DIVIDEND_W-1:0] ui_in,
  input  logic [7:0]            uio_in,
  output logic [7:0]            uo_out,
  output logic [7:0]            uio_out,
  output logic [7:0]            uio_oe
);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN = RUN;
  localparam logic [1:0] S_DONE = DONE;
`ifdef DIVIDER_SELFCHECK_EN
  localparam logic [1:0] S_CHECK = CHECK;
`endif
  logic [1:0]           state_q;
  logic [DIVISOR_W-1:0] pr_q, qs_q, v_q, pr_n, qs_n;
  logic [CNT_W-1:0]     cnt_q;
  logic [7:0]           res_q;
  logic                 start_q, busy_q, done_q, err_q, pend_q;
  logic [DIVISOR_W:0]   t;
  logic                 qb, start_ev, bad;
  logic                 unused_uio;
  assign unused_uio = &{1'b0, uio_in[7:5]};
  assign start_ev = uio_in[START_BIT] & ~start_q;
  assign bad = bad_operands(ui_in, uio_in[DIVISOR_W-1:0]);
  assign t = {pr_q, qs_q[DIVISOR_W-1]};
  assign qb = t >= {1'b0, v_q};
  assign pr_n = qb ? DIVISOR_W'(t - {1'b0, v_q}) : t[DIVISOR_W-1:0];
  assign qs_n = {qs_q[DIVISOR_W-2:0], qb};
`ifdef DIVIDER_SELFCHECK_EN
  logic [DIVIDEND_W-1:0] d_q, prod;
  logic [DIVIDEND_W:0]   chk_sum;
  mul4x4_array u_mul (.a(qs_q), .b(v_q), .p(prod));
  assign chk_sum = {1'b0, prod} + {5'b0, pr_q};
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pr_q <= '0;
      qs_q <= '0;
      v_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      start_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      pend_q <= 1'b0;
`ifdef DIVIDER_SELFCHECK_EN
      d_q <= '0;
`endif
    end else if (ena) begin
      start_q <= uio_in[START_BIT];
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_ev) begin
            done_q <= 1'b0;
            err_q <= 1'b0;
            v_q <= uio_in[DIVISOR_W-1:0];
`ifdef DIVIDER_SELFCHECK_EN
            d_q <= ui_in;
`endif
            // Bad operands report one cycle later through pend_q, never touching busy.
            if (bad) begin
              state_q <= S_DONE;
              pend_q <= 1'b1;
            end else begin
              pr_q <= ui_in[DIVIDEND_W-1:DIVISOR_W];
              qs_q <= ui_in[DIVISOR_W-1:0];
              cnt_q <= CNT_W'(STEPS - 1);
              busy_q <= 1'b1;
              state_q <= S_RUN;
            end
          end else if (pend_q) begin
            pend_q <= 1'b0;
            done_q <= 1'b1;
            err_q <= 1'b1;
            res_q <= ERR_CODE;
          end
        end
        S_RUN: begin
          pr_q <= pr_n;
          qs_q <= qs_n;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
`ifdef DIVIDER_SELFCHECK_EN
            state_q <= S_CHECK;
`else
            state_q <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            res_q <= {pr_n, qs_n};
`endif
          end
        end
`ifdef DIVIDER_SELFCHECK_EN
        S_CHECK: begin
          state_q <= S_DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          err_q <= chk_sum != {1'b0, d_q};
          res_q <= {pr_q, qs_q};
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign uo_out = res_q;
  assign uio_oe = 8'b1110_0000;
  always_comb begin
    uio_out = '0;
    uio_out[ERR_BIT] = err_q;
    uio_out[DONE_BIT] = done_q;
    uio_out[BUSY_BIT] = busy_q;
  end
endmodule
